sd_cmd_engine: RTL and testbench

- Parametrised SD-bus CMD-line engine; successor to the single-purpose SD top level.
- Serialises one 48-bit host command with CRC7, releases the line, waits for the card's response with a timeout, then deserialises it.
- Supports no-response, short (48-bit, with or without CRC) and long (136-bit R2) responses.
- Sits below the SD controller FSM; a separate clock generator supplies the SD-clock strobe.

---
 rtl/sd_cmd_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// SD-bus CMD-line engine: sends a 48-bit command with CRC7, then waits for and captures the card's response.
// Optional receive-side CRC7 checking is enabled by defining SD_CMD_CRC_CHK_EN.
module sd_cmd_engine #(
  parameter int TIMEOUT = 64,
  parameter int NCC     = 8,
  parameter int CNT_W   = 8
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         istrobe,
  input  logic         istart,
  input  logic [5:0]   iindex,
  input  logic [31:0]  iarg,
  input  logic [1:0]   iresp_type,
  input  logic         icmd_in,
  output logic         ocmd_out,
  output logic         ocmd_oe,
  output logic [127:0] oresponse,
  output logic [5:0]   oresp_index,
  output logic         obusy,
  output logic         odone,
  output logic         otimeout,
  output logic         ocrc_err,
  output logic         oframe_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_NCC, S_WAIT, S_RECV, S_CHECK, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(48);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] NCC_LAST   = CNT_W'(NCC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(46);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(134);

  // CRC7 (x^7+x^3+1, zero seed) over up to 120 bits MSB first; leading zeros leave the result unchanged.
  function automatic logic [6:0] crc7(input logic [119:0] data);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 119; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic [1:0]       type_q, type_d;
  logic [47:0]      tx_q, tx_d;
  logic [135:0]     rx_q, rx_d;
  logic             cmd_out_q, cmd_out_d;
  logic             cmd_oe_q, cmd_oe_d;
  logic [127:0]     resp_q, resp_d;
  logic [5:0]       resp_idx_q, resp_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             frame_err_q, frame_err_d;
`ifdef SD_CMD_CRC_CHK_EN
  logic             crc_err_q, crc_err_d;
`endif

  // Start bit and the unchecked long-response bits are never consumed.
  logic unused_s;
  assign unused_s = ^{rx_q[135], rx_q[133:128], rx_q[47], rx_q[7:1]};

  // State and output registers.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 6'd0;
      arg_q       <= 32'd0;
      type_q      <= 2'b00;
      tx_q        <= 48'd0;
      rx_q        <= 136'd0;
      cmd_out_q   <= 1'b1;
      cmd_oe_q    <= 1'b0;
      resp_q      <= 128'd0;
      resp_idx_q  <= 6'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SD_CMD_CRC_CHK_EN
      crc_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      type_q      <= type_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cmd_out_q   <= cmd_out_d;
      cmd_oe_q    <= cmd_oe_d;
      resp_q      <= resp_d;
      resp_idx_q  <= resp_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      frame_err_q <= frame_err_d;
`ifdef SD_CMD_CRC_CHK_EN
      crc_err_q   <= crc_err_d;
`endif
    end
  end

  // Next-state and datapath logic; everything outside LOAD/CHECK/DONE advances only on strobe cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    type_d      = type_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cmd_out_d   = cmd_out_q;
    cmd_oe_d    = cmd_oe_q;
    resp_d      = resp_q;
    resp_idx_d  = resp_idx_q;
    timeout_d   = timeout_q;
    frame_err_d = frame_err_q;
`ifdef SD_CMD_CRC_CHK_EN
    crc_err_d   = crc_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (istart) begin
          idx_d       = iindex;
          arg_d       = iarg;
          type_d      = iresp_type;
          timeout_d   = 1'b0;
          frame_err_d = 1'b0;
`ifdef SD_CMD_CRC_CHK_EN
          crc_err_d   = 1'b0;
`endif
          state_d     = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        tx_d    = {2'b01, idx_q, arg_q, crc7({80'd0, 2'b01, idx_q, arg_q}), 1'b1};
        rx_d    = 136'd0;
        cnt_d   = FRAME_BITS;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (istrobe && (cnt_q != '0)) begin
          cmd_out_d = tx_q[47];
          cmd_oe_d  = 1'b1;
          tx_d      = {tx_q[46:0], 1'b0};
          cnt_d     = cnt_q - CNT_W'(1);
        end else if (istrobe) begin
          cmd_out_d = 1'b1;
          cmd_oe_d  = 1'b0;
          cnt_d     = '0;
          state_d   = (type_q == 2'b00) ? S_NCC : S_WAIT;
        end else begin
          state_d = S_SEND;
        end
      end
      S_NCC: begin
        if (istrobe && (cnt_q == NCC_LAST)) begin
          state_d = S_DONE;
        end else if (istrobe) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_NCC;
        end
      end
      S_WAIT: begin
        // A start bit on the last allowed strobe still counts as a response.
        if (istrobe && !icmd_in) begin
          rx_d    = {rx_q[134:0], icmd_in};
          cnt_d   = (type_q == 2'b10) ? LONG_LAST : SHORT_LAST;
          state_d = S_RECV;
        end else if (istrobe && (cnt_q == TO_LAST)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (istrobe) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RECV: begin
        if (istrobe) begin
          rx_d = {rx_q[134:0], icmd_in};
          if (cnt_q == '0) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_CHECK: begin
        if (type_q == 2'b10) begin
          resp_d      = {rx_q[127:1], 1'b0};
          frame_err_d = rx_q[134] | ~rx_q[0];
        end else begin
          resp_d      = {96'd0, rx_q[39:8]};
          resp_idx_d  = rx_q[45:40];
          frame_err_d = rx_q[46] | ~rx_q[0];
        end
`ifdef SD_CMD_CRC_CHK_EN
        case (type_q)
          2'b01:   crc_err_d = (crc7({80'd0, rx_q[47:8]}) != rx_q[7:1]);
          2'b10:   crc_err_d = (crc7(rx_q[127:8]) != rx_q[7:1]);
          default: crc_err_d = 1'b0;
        endcase
`endif
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign ocmd_out    = cmd_out_q;
  assign ocmd_oe     = cmd_oe_q;
  assign oresponse   = resp_q;
  assign oresp_index = resp_idx_q;
  assign obusy       = busy_q;
  assign odone       = done_q;
  assign otimeout    = timeout_q;
  assign oframe_err  = frame_err_q;
`ifdef SD_CMD_CRC_CHK_EN
  assign ocrc_err    = crc_err_q;
`else
  assign ocrc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed, table-driven bench for sd_cmd_engine with a bit-serial card model and hand-made corner sequences.
module tb_sd_cmd_engine;

  localparam int TIMEOUT = 64;
  localparam int NCC     = 8;
`ifdef SD_CMD_CRC_CHK_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic         iclk, irst, istrobe, istart, icmd_in;
  logic [5:0]   iindex;
  logic [31:0]  iarg;
  logic [1:0]   iresp_type;
  logic         ocmd_out, ocmd_oe, obusy, odone, otimeout, ocrc_err, oframe_err;
  logic [127:0] oresponse;
  logic [5:0]   oresp_index;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  sd_cmd_engine #(.TIMEOUT(TIMEOUT), .NCC(NCC), .CNT_W(8)) dut (
    .iclk(iclk), .irst(irst), .istrobe(istrobe), .istart(istart),
    .iindex(iindex), .iarg(iarg), .iresp_type(iresp_type), .icmd_in(icmd_in),
    .ocmd_out(ocmd_out), .ocmd_oe(ocmd_oe), .oresponse(oresponse),
    .oresp_index(oresp_index), .obusy(obusy), .odone(odone),
    .otimeout(otimeout), .ocrc_err(ocrc_err), .oframe_err(oframe_err)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(posedge iclk) if (odone) done_cnt++;

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    logic [47:0]  tx;
    logic [135:0] resp;
    int           len;
    int           delay;
    int           glitch;
    logic [127:0] exp_resp;
    logic [5:0]   exp_idx;
    logic         exp_to;
    logic         exp_crc;
    logic         exp_frm;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [6:0] ref_crc7(input logic [119:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 119; i >= 0; i--) begin
      if (c[6] ^ d[i]) c = {c[5:0], 1'b0} ^ 7'h09;
      else             c = {c[5:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, ref_crc7({80'd0, 2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_strobe();
    @(negedge iclk);
    istrobe = 1'b1;
    @(negedge iclk);
    istrobe = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [47:0] cap;
    logic        oe_ok;
    int          seen;
    int          d0;
    d0 = done_cnt;
    @(negedge iclk);
    iindex = v.idx; iarg = v.arg; iresp_type = v.rtype; istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    check({tag, " busy"}, 136'(obusy), 136'(1'b1));
    cap = 48'd0; oe_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      do_strobe();
      cap = {cap[46:0], ocmd_out};
      if (!ocmd_oe) oe_ok = 1'b0;
      if (i == v.glitch) begin
        iindex = 6'h3F; iarg = 32'hFFFF_FFFF; iresp_type = 2'b01; istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
      end
    end
    check({tag, " tx frame"}, 136'(cap), 136'(v.tx));
    check({tag, " tx oe"}, 136'(oe_ok), 136'(1'b1));
    do_strobe();
    check({tag, " release"}, 136'({ocmd_oe, ocmd_out}), 136'(2'b01));
    seen = 0;
    if (v.rtype == 2'b00) begin
      for (int k = 1; k <= NCC + 3; k++) begin
        do_strobe();
        if (odone) begin seen = k; break; end
      end
      check({tag, " ncc done strobe"}, 136'(seen), 136'(NCC));
    end else begin
      icmd_in = 1'b1;
      for (int k = 1; k <= v.delay; k++) begin
        do_strobe();
        if (odone) begin seen = k; break; end
      end
      if (v.len == 0) begin
        check({tag, " timeout strobe"}, 136'(seen), 136'(TIMEOUT));
      end else begin
        check({tag, " early done"}, 136'(seen), 136'(0));
        for (int j = v.len - 1; j >= 0; j--) begin
          icmd_in = v.resp[j];
          do_strobe();
        end
        icmd_in = 1'b1;
        for (int k = 0; k < 10 && !odone; k++) @(negedge iclk);
        check({tag, " done seen"}, 136'(odone), 136'(1'b1));
        check({tag, " response"}, 136'(oresponse), 136'(v.exp_resp));
        if (v.rtype != 2'b10) check({tag, " resp index"}, 136'(oresp_index), 136'(v.exp_idx));
      end
    end
    check({tag, " flags"}, 136'({otimeout, ocrc_err, oframe_err}),
          136'({v.exp_to, v.exp_crc, v.exp_frm}));
    @(negedge iclk);
    @(negedge iclk);
    check({tag, " done width"}, 136'(done_cnt - d0), 136'(1));
    check({tag, " idle"}, 136'({obusy, odone}), 136'(2'b00));
  endtask

  initial begin
    logic [119:0] cid;
    logic [135:0] r2;
    irst = 1'b0; istrobe = 1'b0; istart = 1'b0; icmd_in = 1'b1;
    iindex = 6'd0; iarg = 32'd0; iresp_type = 2'b00;

    cid = 120'h0123456789ABCDEF_FEDCBA98765432;
    r2  = {2'b00, 6'h3F, cid, ref_crc7(cid), 1'b1};
    //        idx    arg            type   tx frame                        resp                 len  delay          glitch exp_resp              eidx   to    crc     frm
    tbl[0] = '{6'd0,  32'h0000_0000, 2'b00, 48'h400000000095,       136'd0,              0,   0,             5,  128'd0,               6'd0,  1'b0, 1'b0,   1'b0};
    tbl[1] = '{6'd8,  32'h0000_01AA, 2'b01, 48'h48000001AA87,       136'h08000001AA13,   48,  5,            -1,  128'h1AA,             6'd8,  1'b0, 1'b0,   1'b0};
    tbl[2] = '{6'd8,  32'h0000_01AA, 2'b01, 48'h48000001AA87,       136'h08000001AA15,   48,  5,            -1,  128'h1AA,             6'd8,  1'b0, CRC_ON, 1'b0};
    tbl[3] = '{6'd8,  32'h0000_01AA, 2'b01, 48'h48000001AA87,       136'h08000001AA12,   48,  2,            -1,  128'h1AA,             6'd8,  1'b0, 1'b0,   1'b1};
    tbl[4] = '{6'd41, 32'h40FF_8000, 2'b11, mk_frame(6'd41, 32'h40FF_8000), 136'h3F80FF8000FF, 48, 3,   -1,  128'h80FF8000,        6'h3F, 1'b0, 1'b0,   1'b0};
    tbl[5] = '{6'd2,  32'h0000_0000, 2'b10, mk_frame(6'd2, 32'h0), 136'd0,               0,   TIMEOUT + 3,  -1,  128'd0,               6'd0,  1'b1, 1'b0,   1'b0};
    tbl[6] = '{6'd2,  32'h0000_0000, 2'b10, mk_frame(6'd2, 32'h0), r2,                   136, TIMEOUT - 1,  -1,  {r2[127:1], 1'b0},    6'd0,  1'b0, 1'b0,   1'b0};

    repeat (3) @(negedge iclk);
    check("reset line", 136'({ocmd_oe, ocmd_out}), 136'(2'b01));
    check("reset response", 136'({oresponse, oresp_index}), 136'd0);
    check("reset status", 136'({obusy, odone, otimeout, ocrc_err, oframe_err}), 136'd0);
    irst = 1'b1;
    @(negedge iclk);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a transmission.
    @(negedge iclk);
    iindex = 6'd8; iarg = 32'h1AA; iresp_type = 2'b01; istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    for (int i = 0; i < 10; i++) do_strobe();
    check("mid-send oe", 136'(ocmd_oe), 136'(1'b1));
    #2 irst = 1'b0;
    #1;
    check("abort line", 136'({ocmd_oe, ocmd_out}), 136'(2'b01));
    check("abort status", 136'({obusy, odone, otimeout, oresponse}), 136'd0);
    @(negedge iclk);
    irst = 1'b1;
    run_vec(tbl[1], "after-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
